// File: rtl/tens_digit_timer_if.sv
// Signal bundle between the tens-digit timer and its surroundings.
// The master side (ones-digit timer / game controller) drives the
// requests; the slave side (tens_digit_timer) drives the digit, status
// and warning outputs.
interface tens_digit_timer_if;
  logic       reconfig;
  logic [3:0] tens_load;
  logic       tens_timer_in;
  logic       game_timeout;
  logic       one_sec_in;
  logic [3:0] tens_d_out;
  logic       DNB_out_10s;
  logic       borrow_err;
  logic [1:0] state_out;
  logic       warn_out;

  modport master (
    output reconfig, tens_load, tens_timer_in, game_timeout, one_sec_in,
    input  tens_d_out, DNB_out_10s, borrow_err, state_out, warn_out
  );

  modport slave (
    input  reconfig, tens_load, tens_timer_in, game_timeout, one_sec_in,
    output tens_d_out, DNB_out_10s, borrow_err, state_out, warn_out
  );
endinterface

// File: rtl/tens_digit_timer.sv
// Tens digit of a BCD game countdown timer.
// Holds the tens digit, accepts borrow requests from the ones-digit
// timer, flags illegal borrows and tracks IDLE/RUN/EXPIRED game state.
// Optional low-time warning blinker is built only when the macro
// TENS_WARN_EN is defined; otherwise warn_out is tied low.
module tens_digit_timer (
  input  logic            clk,
  input  logic            reset,
  tens_digit_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       borrow_err_q, borrow_err_d;

  // Next-state rules: reconfig beats timeout, timeout beats borrow.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    borrow_err_d = 1'b0;
    if (bus.reconfig) begin
      state_d = RUN;
      digit_d = (bus.tens_load > 4'd9) ? 4'd9 : bus.tens_load;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.game_timeout) begin
            state_d = EXPIRED;
          end else if (bus.tens_timer_in) begin
            if (digit_q != 4'd0) begin
              digit_d = digit_q - 4'd1;
            end else begin
              borrow_err_d = 1'b1;
            end
          end
        end
        IDLE:    state_d = IDLE;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, digit and error pulse registers; reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      digit_q      <= 4'd0;
      borrow_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      borrow_err_q <= borrow_err_d;
    end
  end

  assign bus.tens_d_out  = digit_q;
  assign bus.state_out   = state_q;
  assign bus.borrow_err  = borrow_err_q;
  assign bus.DNB_out_10s = (digit_q == 4'd0);

`ifdef TENS_WARN_EN
  logic warn_q, warn_d;

  // Warning blinks at 1 Hz while running on a zero tens digit, stays lit after expiry.
  always_comb begin
    warn_d = warn_q;
    if (bus.reconfig) begin
      warn_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.game_timeout) begin
            warn_d = 1'b1;
          end else if (digit_d != 4'd0) begin
            warn_d = 1'b0;
          end else if ((digit_q == 4'd0) && bus.one_sec_in) begin
            warn_d = ~warn_q;
          end
        end
        EXPIRED: warn_d = 1'b1;
        default: warn_d = 1'b0;
      endcase
    end
  end

  // Warning register, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign bus.warn_out = warn_q;
`else
  logic unused_one_sec;
  assign unused_one_sec = bus.one_sec_in;
  assign bus.warn_out   = 1'b0;
`endif

endmodule

// File: tb/tb_tens_digit_timer.sv
// Scoreboard bench for tens_digit_timer: directed scenarios plus random
// traffic, checked against a game-level reference model.
module tb_tens_digit_timer;

  typedef struct {
    logic [3:0] digit;
    logic       dnb;
    logic       berr;
    logic [1:0] st;
    logic       warn;
  } exp_t;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tens_digit_timer_if bus();

  tens_digit_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: game mode, digit as integer, count of 1 Hz ticks on zero.
  int m_mode       = M_IDLE;
  int m_digit      = 0;
  int m_zero_ticks = 0;

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_digit      = 0;
    m_zero_ticks = 0;
  endtask

  task automatic model_step(input bit rc, input int load, input bit tmr, input bit tmo,
                            input bit sec, output exp_t e);
    int old_digit = m_digit;
    e.berr = 1'b0;
    if (rc) begin
      m_digit      = (load > 9) ? 9 : load;
      m_mode       = M_RUN;
      m_zero_ticks = 0;
    end else if (m_mode == M_RUN) begin
      if (tmo) m_mode = M_EXP;
      else if (tmr) begin
        if (m_digit > 0) m_digit = m_digit - 1;
        else e.berr = 1'b1;
      end
      if (m_mode == M_RUN) begin
        if (m_digit > 0) m_zero_ticks = 0;
        else if (old_digit == 0 && sec) m_zero_ticks = m_zero_ticks + 1;
      end
    end
    e.digit = 4'(m_digit);
    e.dnb   = (m_digit == 0);
    e.st    = 2'(m_mode);
`ifdef TENS_WARN_EN
    e.warn  = (m_mode == M_EXP) ? 1'b1 :
              (m_mode == M_RUN) ? ((m_zero_ticks % 2) == 1) : 1'b0;
`else
    e.warn  = 1'b0;
`endif
  endtask

  task automatic apply_stimulus(input bit rc, input int load, input bit tmr, input bit tmo,
                                input bit sec);
    exp_t e;
    @(negedge clk);
    bus.reconfig      = rc;
    bus.tens_load     = 4'(load);
    bus.tens_timer_in = tmr;
    bus.game_timeout  = tmo;
    bus.one_sec_in    = sec;
    model_step(rc, load, tmr, tmo, sec, e);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_digit", bus.tens_d_out, 4'd0);
    check_output("rst_dnb",   {3'b0, bus.DNB_out_10s}, 4'd1);
    check_output("rst_state", {2'b0, bus.state_out}, 4'd0);
    check_output("rst_berr",  {3'b0, bus.borrow_err}, 4'd0);
    check_output("rst_warn",  {3'b0, bus.warn_out}, 4'd0);
  endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    bus.reconfig      = 1'b0;
    bus.tens_timer_in = 1'b0;
    bus.game_timeout  = 1'b0;
    bus.one_sec_in    = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a new output set after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("digit",  bus.tens_d_out, e.digit);
        check_output("dnb",    {3'b0, bus.DNB_out_10s}, {3'b0, e.dnb});
        check_output("berr",   {3'b0, bus.borrow_err}, {3'b0, e.berr});
        check_output("state",  {2'b0, bus.state_out}, {2'b0, e.st});
        check_output("warn",   {3'b0, bus.warn_out}, {3'b0, e.warn});
      end
    end
  end

  initial begin
    bus.reconfig      = 1'b0;
    bus.tens_load     = 4'd0;
    bus.tens_timer_in = 1'b0;
    bus.game_timeout  = 1'b0;
    bus.one_sec_in    = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Idle: borrows and timeouts ignored.
    apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    // Oversized preset saturates to 9.
    apply_stimulus(1, 12, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    // Reset mid-game with digit 5, then stays idle.
    apply_stimulus(1, 5, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    do_reset();
    apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    // Count 2 down past zero: 1, 0, 0 with a borrow error.
    apply_stimulus(1, 2, 0, 0, 0);
    repeat (3) apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    // Timeout wins over borrow; later borrows ignored; reconfig restarts.
    apply_stimulus(1, 3, 0, 0, 0);
    apply_stimulus(0, 0, 1, 1, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    // Reconfig wins over borrow.
    apply_stimulus(1, 6, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    // Warning blink on zero digit, held after timeout.
    apply_stimulus(1, 0, 0, 0, 0);
    repeat (4) begin
      apply_stimulus(0, 0, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 0);
    end
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        apply_stimulus($urandom_range(0, 15) == 0, int'($urandom_range(0, 15)),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                       $urandom_range(0, 2) == 0);
      end
    end
    apply_stimulus(0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tens_digit_timer.md
TENS_DIGIT_TIMER -- requirements
Module: tens_digit_timer

Interface
REQ-001 The block SHALL provide `clk`, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL provide `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL provide `reconfig`, input, 1 bit: start a new game and load the preset.
REQ-004 The block SHALL provide `tens_load`, input, 4 bits: tens-digit preset in BCD.
REQ-005 The block SHALL provide `tens_timer_in`, input, 1 bit: one-cycle borrow request from the ones-digit timer.
REQ-006 The block SHALL provide `game_timeout`, input, 1 bit: expiry indication from the ones-digit timer.
REQ-007 The block SHALL provide `one_sec_in`, input, 1 bit: one-cycle 1 Hz tick, used only by the warning feature.
REQ-008 The block SHALL provide `tens_d_out`, output, 4 bits: current tens digit in BCD, 0-9.
REQ-009 The block SHALL provide `DNB_out_10s`, output, 1 bit: "do not borrow", high when the tens digit is 0.
REQ-010 The block SHALL provide `borrow_err`, output, 1 bit: one-cycle pulse on an illegal borrow.
REQ-011 The block SHALL provide `state_out`, output, 2 bits: FSM state, IDLE=00, RUN=01, EXPIRED=10.
REQ-012 The block SHALL provide `warn_out`, output, 1 bit: low-time warning indicator.

Function
REQ-013 FSM states SHALL be IDLE, RUN and EXPIRED; encoding 11 is unreachable and SHALL recover to IDLE on the next edge.
REQ-014 `reconfig`=1 in any state SHALL, at the next edge:
  - load `tens_d_out` with `tens_load`, saturated to 9 if greater than 9;
  - enter RUN;
  - clear `borrow_err`.
REQ-015 In RUN, `tens_timer_in`=1 with `tens_d_out`>0 SHALL decrement `tens_d_out` by 1 at the next edge; no wrap-around.
REQ-016 In RUN, `tens_timer_in`=1 with `tens_d_out`=0 SHALL hold the digit at 0 and pulse `borrow_err` high for exactly one cycle.
REQ-017 `DNB_out_10s` SHALL equal (`tens_d_out`==0), decoded from the digit register with zero-cycle latency so the ones timer sees it in the same cycle.
REQ-018 In RUN, `game_timeout`=1 SHALL enter EXPIRED at the next edge with `tens_d_out` held.
REQ-019 In IDLE and EXPIRED, `tens_timer_in` and `game_timeout` SHALL be ignored; no decrement and no `borrow_err`.
REQ-020 Priority when events coincide SHALL be: reset > `reconfig` > `game_timeout` > `tens_timer_in`.
REQ-021 `tens_timer_in` and `game_timeout` in the same RUN cycle SHALL enter EXPIRED without decrementing.
REQ-022 Without `reconfig`, only EXPIRED->EXPIRED, IDLE->IDLE and RUN->{RUN, EXPIRED} transitions SHALL be possible.

Reset
REQ-023 `reset`=1 SHALL immediately, without waiting for a clock edge, force:
  - `tens_d_out`=0 and therefore `DNB_out_10s`=1;
  - `state_out`=IDLE;
  - `borrow_err`=0;
  - `warn_out`=0.
REQ-024 Reset asserted mid-game SHALL discard the count; after deassertion the block SHALL remain in IDLE until `reconfig`.

Configuration
REQ-025 Macro TENS_WARN_EN defined: in RUN with `tens_d_out`=0, `warn_out` SHALL toggle on each `one_sec_in` pulse; it SHALL be 0 in RUN with `tens_d_out`>0 and in IDLE; it SHALL be held 1 in EXPIRED.
REQ-026 The warning toggle SHALL be cleared to 0 on entry to RUN via `reconfig`.
REQ-027 Macro TENS_WARN_EN undefined: `warn_out` SHALL be constant 0 and no warning logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-028 Reset pulse mid-RUN with digit 5 -> outputs go to 0/IDLE immediately, without a clock edge; `DNB_out_10s`=1.
REQ-029 `reconfig` with `tens_load`=4'hC -> next edge `tens_d_out`=9, `state_out`=01, `DNB_out_10s`=0.
REQ-030 `reconfig` with `tens_load`=2, then 3 `tens_timer_in` pulses -> digit goes 1, 0, 0; the third pulse gives a one-cycle `borrow_err`; `DNB_out_10s`=1 from the cycle the digit reaches 0.
REQ-031 RUN with digit 3, `game_timeout` and `tens_timer_in` in the same cycle -> EXPIRED with digit 3; later borrows are ignored; `reconfig` with `tens_load`=1 returns to RUN with digit 1.
REQ-032 `reconfig` and `tens_timer_in` in the same cycle with `tens_load`=6 -> digit 6, no decrement.
REQ-033 TENS_WARN_EN build, RUN with digit 0, four `one_sec_in` pulses -> `warn_out` reads 1, 0, 1, 0; after `game_timeout` it is held at 1. Non-TENS_WARN_EN build -> `warn_out` stays 0 throughout.
